// File: rtl/shift_reg_seq.sv
// Universal shift register engine: clear/load/shift/rotate with a command
// handshake. Multi-bit shifts execute one bit per clock.
module shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] d_in,
  input  logic             s_in,
  output logic [WIDTH-1:0] reg_out,
  output logic             s_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_LSL  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_ROL  = 3'b111;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // latched shift command: op plus remaining step count
  typedef struct packed {
    logic [2:0]       op;
    logic [AMT_W-1:0] count;
  } shift_cmd_t;

  state_t           state, state_nxt;
  shift_cmd_t       cur, cur_nxt;
  logic [WIDTH-1:0] reg_nxt, step_reg;
  logic             s_out_nxt, done_nxt, step_bit;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == SHIFT);

  // single-bit step of the latched op and the bit that leaves the register
  always_comb begin
    step_reg = reg_out;
    step_bit = s_out;
    case (cur.op)
      OP_LSR: begin step_reg = {1'b0, reg_out[WIDTH-1:1]};          step_bit = reg_out[0];       end
      OP_LSL: begin step_reg = {reg_out[WIDTH-2:0], 1'b0};          step_bit = reg_out[WIDTH-1]; end
      OP_ASR: begin step_reg = {reg_out[WIDTH-1], reg_out[WIDTH-1:1]}; step_bit = reg_out[0];    end
      OP_SLL: begin step_reg = {reg_out[WIDTH-2:0], s_in};          step_bit = reg_out[WIDTH-1]; end
      OP_ROR: begin step_reg = {reg_out[0], reg_out[WIDTH-1:1]};    step_bit = reg_out[0];       end
      OP_ROL: begin step_reg = {reg_out[WIDTH-2:0], reg_out[WIDTH-1]}; step_bit = reg_out[WIDTH-1]; end
      default: ;
    endcase
  end

  // next state: accept in IDLE, step and count down in SHIFT
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    reg_nxt   = reg_out;
    s_out_nxt = s_out;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_CLR) begin
            reg_nxt  = '0;
            done_nxt = 1'b1;
          end else if (cmd_op == OP_LOAD) begin
            reg_nxt  = d_in;
            done_nxt = 1'b1;
          end else if (cmd_amt == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt     = SHIFT;
            cur_nxt.op    = cmd_op;
            cur_nxt.count = cmd_amt;
          end
        end
      end
      SHIFT: begin
        reg_nxt       = step_reg;
        s_out_nxt     = step_bit;
        cur_nxt.count = cur.count - AMT_W'(1);
        if (cur.count == AMT_W'(1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state and datapath registers, async active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cur     <= '0;
      reg_out <= '0;
      s_out   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cur     <= cur_nxt;
      reg_out <= reg_nxt;
      s_out   <= s_out_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: directed scenarios plus randomized commands
// checked against a closed-form shift/rotate model.
module tb_shift_reg_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [3:0]   cmd_amt = '0;
  logic [W-1:0] d_in = '0;
  logic         s_in = 1'b0;
  logic [W-1:0] reg_out;
  logic         s_out, busy, done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_reg = '0;
  logic         exp_sout = 1'b0;

  shift_reg_seq #(.WIDTH(W), .AMT_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .d_in(d_in), .s_in(s_in),
    .reg_out(reg_out), .s_out(s_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Closed-form result of a whole command applied to the expected register.
  task automatic model_apply(input logic [2:0] op, input int n, input logic [W-1:0] d,
                             input logic [15:0] sseq);
    logic [63:0] full;
    logic [63:0] sb;
    logic [W-1:0] res;
    if (op == 3'd0) exp_reg = '0;
    else if (op == 3'd1) exp_reg = d;
    else if (n != 0) begin
      full = '0;
      res  = exp_reg;
      case (op)
        3'd2: begin full = 64'(exp_reg); exp_sout = full[n-1]; full = full >> n; res = full[W-1:0]; end
        3'd3: begin full = 64'(exp_reg) << n; exp_sout = full[W]; res = full[W-1:0]; end
        3'd4: begin
          full = {{(64-W){exp_reg[W-1]}}, exp_reg};
          exp_sout = full[n-1]; full = full >> n; res = full[W-1:0];
        end
        3'd5: begin
          sb = '0;
          for (int i = 0; i < n; i++) sb = (sb << 1) | 64'(sseq[i]);
          full = (64'(exp_reg) << n) | sb;
          exp_sout = full[W]; res = full[W-1:0];
        end
        3'd6: begin full = 64'({exp_reg, exp_reg}) >> (n % W); res = full[W-1:0]; exp_sout = res[W-1]; end
        default: begin full = 64'({exp_reg, exp_reg}) << (n % W); res = full[2*W-1:W]; exp_sout = res[0]; end
      endcase
      exp_reg = res;
    end
  endtask

  // Drive one command starting at a negedge; return at the negedge where
  // done is seen (or after a cycle budget expires).
  task automatic issue(input logic [2:0] op, input logic [3:0] amt, input logic [W-1:0] d,
                       input logic [15:0] sseq, output int busy_n, output int nready_n,
                       output bit got_done);
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; d_in = d; s_in = sseq[0];
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    busy_n = 0; nready_n = 0; got_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin got_done = 1'b1; break; end
      if (busy) busy_n++;
      if (!cmd_ready) nready_n++;
      if (c < 16) s_in = sseq[c];
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (reg_out !== '0 || s_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: reg=%h s_out=%b busy=%b done=%b, want 00/0/0/0", reg_out, s_out, busy, done);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: cmd_ready=%b want 1", cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_asr;
    int bn, rn; bit gd;
    issue(3'd1, 4'd0, 8'hB5, 16'h0, bn, rn, gd); model_apply(3'd1, 0, 8'hB5, 16'h0);
    issue(3'd4, 4'd3, 8'h00, 16'h0, bn, rn, gd); model_apply(3'd4, 3, 8'h00, 16'h0);
    checks++;
    if (!gd || reg_out !== 8'hF6 || s_out !== 1'b1) begin
      errors++; $display("FAIL asr3: done=%b reg=%h s_out=%b, want 1/f6/1", gd, reg_out, s_out);
    end
    checks++;
    if (rn != 3 || bn != 3) begin errors++; $display("FAIL asr3_timing: not_ready=%0d busy=%0d want 3/3", rn, bn); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL asr3_done_width: done=%b want 0", done); end
  endtask

  task automatic test_rotate_wrap;
    int bn, rn; bit gd;
    issue(3'd1, 4'd0, 8'h81, 16'h0, bn, rn, gd); model_apply(3'd1, 0, 8'h81, 16'h0);
    issue(3'd7, 4'd11, 8'h00, 16'h0, bn, rn, gd); model_apply(3'd7, 11, 8'h00, 16'h0);
    checks++;
    if (!gd || bn != 11 || reg_out !== 8'h0C) begin
      errors++; $display("FAIL rol11: done=%b busy=%0d reg=%h, want 1/11/0c", gd, bn, reg_out);
    end
  endtask

  task automatic test_lsl_overflow;
    int bn, rn; bit gd;
    issue(3'd1, 4'd0, 8'hFF, 16'h0, bn, rn, gd); model_apply(3'd1, 0, 8'hFF, 16'h0);
    issue(3'd3, 4'd9, 8'h00, 16'h0, bn, rn, gd); model_apply(3'd3, 9, 8'h00, 16'h0);
    checks++;
    if (!gd || bn != 9 || reg_out !== 8'h00 || s_out !== 1'b0) begin
      errors++; $display("FAIL lsl9: done=%b busy=%0d reg=%h s_out=%b, want 1/9/00/0", gd, bn, reg_out, s_out);
    end
  endtask

  task automatic test_serial;
    int bn, rn; bit gd;
    issue(3'd1, 4'd0, 8'h00, 16'h0, bn, rn, gd); model_apply(3'd1, 0, 8'h00, 16'h0);
    issue(3'd5, 4'd4, 8'h00, 16'hD, bn, rn, gd); model_apply(3'd5, 4, 8'h00, 16'hD);
    checks++;
    if (!gd || reg_out !== 8'h0B) begin errors++; $display("FAIL serial4: done=%b reg=%h want 1/0b", gd, reg_out); end
  endtask

  task automatic test_back_to_back;
    int bn, rn; bit gd;
    logic so_before;
    issue(3'd1, 4'd0, 8'h5A, 16'h0, bn, rn, gd); model_apply(3'd1, 0, 8'h5A, 16'h0);
    so_before = s_out;
    issue(3'd2, 4'd0, 8'h00, 16'h0, bn, rn, gd); model_apply(3'd2, 0, 8'h00, 16'h0);
    checks++;
    if (!gd || bn != 0 || rn != 0 || reg_out !== 8'h5A || s_out !== so_before) begin
      errors++; $display("FAIL amt0: done=%b busy=%0d reg=%h s_out=%b, want 1/0/5a/%b", gd, bn, reg_out, s_out, so_before);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL done_cycle_ready: cmd_ready=%b want 1", cmd_ready); end
    issue(3'd1, 4'd0, 8'h33, 16'h0, bn, rn, gd); model_apply(3'd1, 0, 8'h33, 16'h0);
    checks++;
    if (!gd || reg_out !== 8'h33) begin errors++; $display("FAIL b2b_load: done=%b reg=%h want 1/33", gd, reg_out); end
  endtask

  task automatic test_reset_mid_shift;
    int bn, rn; bit gd;
    issue(3'd1, 4'd0, 8'h01, 16'h0, bn, rn, gd);
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_amt = 4'd6;
    @(posedge clk); @(negedge clk); cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; d_in = 8'hAA;
    @(posedge clk); @(negedge clk); cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || reg_out !== 8'h40) begin
      errors++; $display("FAIL ignore_while_busy: busy=%b reg=%h want 1/40", busy, reg_out);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (reg_out !== '0 || busy !== 1'b0 || done !== 1'b0 || s_out !== 1'b0) begin
      errors++; $display("FAIL mid_reset: reg=%h busy=%b done=%b s_out=%b want 00/0/0/0", reg_out, busy, done, s_out);
    end
    @(negedge clk); reset = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_release: ready=%b busy=%b want 1/0", cmd_ready, busy);
    end
    exp_reg = '0; exp_sout = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    int bn, rn; bit gd;
    logic [2:0]  op;
    logic [3:0]  amt;
    logic [W-1:0] d;
    logic [15:0] sseq;
    int exp_busy;
    for (int it = 0; it < 40; it++) begin
      op = 3'($urandom_range(0, 7)); amt = 4'($urandom_range(0, 15));
      d = 8'($urandom); sseq = 16'($urandom);
      if (it % 3 == 0) begin
        issue(3'd1, 4'd0, d, 16'h0, bn, rn, gd); model_apply(3'd1, 0, d, 16'h0);
      end
      issue(op, amt, d, sseq, bn, rn, gd);
      model_apply(op, int'(amt), d, sseq);
      exp_busy = (op >= 3'd2) ? int'(amt) : 0;
      checks++;
      if (!gd || bn != exp_busy || rn != exp_busy) begin
        errors++; $display("FAIL rand%0d_timing op=%0d amt=%0d: done=%b busy=%0d not_ready=%0d want busy %0d", it, op, amt, gd, bn, rn, exp_busy);
      end
      checks++;
      if (reg_out !== exp_reg || s_out !== exp_sout) begin
        errors++; $display("FAIL rand%0d_data op=%0d amt=%0d: reg=%h s_out=%b want %h/%b", it, op, amt, reg_out, s_out, exp_reg, exp_sout);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL rand%0d_done_width: done=%b want 0", it, done); end
    end
  endtask

  initial begin
    test_reset();
    test_asr();
    test_rotate_wrap();
    test_lsl_overflow();
    test_serial();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
